// File: rtl/ds_ex_reg.sv
// ----------------------------------------------------------------------------
// ds_ex_reg - decode-to-execute pipeline register
//
// Accepts decoded packets from the decode stage over a valid/allow-in
// handshake, holds them for the execute stage in arrival order, applies
// back-pressure upstream, and squashes held packets on a branch-redirect flush.
//
// Configuration macro: DS_EX_REG_SKID_EN
//   defined   : 2-entry skid buffer (main + skid). ds_ex_reg_allow_in depends
//               only on registered occupancy and flush, never on ex_allow_in.
//   undefined : single-entry register. ds_ex_reg_allow_in is combinational
//               from ex_allow_in.
//
// Ports
//   clk                 in   clock, rising-edge
//   reset               in   asynchronous reset, active low
//   ds_to_ex_reg_valid  in   decode presents a valid packet
//   ds_data             in   decoded packet [DS_DATA_W]
//   ds_ex_reg_allow_in  out  register can accept a packet this cycle
//   flush               in   branch redirect, squash everything held/incoming
//   ex_allow_in         in   execute consumes the head packet this cycle
//   ex_valid            out  head packet valid
//   ex_data             out  head packet [DS_DATA_W]
// ----------------------------------------------------------------------------
module ds_ex_reg #(
    parameter int DS_DATA_W = 96
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ds_to_ex_reg_valid,
    input  logic [DS_DATA_W-1:0] ds_data,
    output logic                 ds_ex_reg_allow_in,
    input  logic                 flush,
    input  logic                 ex_allow_in,
    output logic                 ex_valid,
    output logic [DS_DATA_W-1:0] ex_data
);

    logic accept;
    logic drain;

    assign accept = ds_to_ex_reg_valid && ds_ex_reg_allow_in;
    assign drain  = ex_valid && ex_allow_in;

`ifdef DS_EX_REG_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e                 state;
    occ_e                 state_nxt;
    logic [DS_DATA_W-1:0] main_data;
    logic [DS_DATA_W-1:0] skid_data;
    logic                 load_main_ds;
    logic                 load_main_skid;
    logic                 load_skid;

    // Registered occupancy is the only non-flush term, so upstream timing
    // never sees the execute-stage stall path.
    assign ds_ex_reg_allow_in = (state != FULL) && !flush;
    assign ex_valid           = (state != EMPTY);
    assign ex_data            = main_data;

    always_comb begin
        // NOTE: every signal written here gets a default first; otherwise a
        // path that skips an assignment infers a latch.
        state_nxt      = state;
        load_main_ds   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_ds = 1'b1;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (accept && drain) begin
                    load_main_ds = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // allow-in is low here, so only a drain can move state
                if (drain) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A flush discards both entries; accept is already blocked by allow-in.
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the data registers are reset because ex_data must read zero out
    // of reset; otherwise they would need no reset, since valids qualify them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_ds) begin
                main_data <= ds_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= ds_data;
            end
        end
    end

`else

    logic                 valid_q;
    logic [DS_DATA_W-1:0] data_q;

    // The slot frees up in the same cycle execute consumes the head.
    assign ds_ex_reg_allow_in = (!valid_q || ex_allow_in) && !flush;
    assign ex_valid           = valid_q;
    assign ex_data            = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                data_q <= ds_data;
            end
        end
    end

`endif

endmodule

// File: tb/tb_ds_ex_reg.sv
// ----------------------------------------------------------------------------
// tb_ds_ex_reg - self-checking bench for ds_ex_reg (either configuration)
//
// The driver issues one beat per cycle and, from its own occupancy model,
// pushes each accepted packet into an expected queue. A separate monitor
// compares valid, head data and allow-in against that queue every cycle and
// pops on drains / clears on flushes. Directed sequences add hand-computed
// checks on reset, latency, stall, flush and mid-stream reset.
// ----------------------------------------------------------------------------
module tb_ds_ex_reg;

    localparam int W = 96;
`ifdef DS_EX_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ds_valid = 1'b0;
    logic [W-1:0] ds_data = '0;
    logic         flush = 1'b0;
    logic         ex_allow_in = 1'b0;
    logic         allow;
    logic         ex_valid;
    logic [W-1:0] ex_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    ds_ex_reg #(.DS_DATA_W(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_to_ex_reg_valid(ds_valid),
        .ds_data           (ds_data),
        .ds_ex_reg_allow_in(allow),
        .flush             (flush),
        .ex_allow_in       (ex_allow_in),
        .ex_valid          (ex_valid),
        .ex_data           (ex_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference allow-in from the bench's own occupancy count.
    function automatic logic model_allow(input int held, input logic ea, input logic fl);
        if (fl) return 1'b0;
        if (SKID) return held < 2;
        return (held == 0) || ea;
    endfunction

    // One beat: drive at negedge, record the expected accept at the posedge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ea,
                         input logic fl, output logic acc);
        @(negedge clk);
        ds_valid    = v;
        ds_data     = d;
        ex_allow_in = ea;
        flush       = fl;
        acc = v && model_allow(exp_q.size(), ea, fl);
        @(posedge clk);
        if (acc) exp_q.push_back(d);
    endtask

    // Monitor: samples mid-cycle, retires on the following edge.
    initial begin : monitor
        logic dr;
        logic fl;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                check("valid", W'(ex_valid), W'(exp_q.size() != 0));
                if (exp_q.size() != 0) check("head_data", ex_data, exp_q[0]);
                check("allow_in", W'(allow), W'(model_allow(exp_q.size(), ex_allow_in, flush)));
                dr = (exp_q.size() != 0) && ex_allow_in;
                fl = flush;
                @(posedge clk);
                if (dr && exp_q.size() != 0) void'(exp_q.pop_front());
                if (fl) exp_q.delete();
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic         acc;
        logic [W-1:0] pk[3];
        logic [W-1:0] d;
        logic [W-1:0] seq;
        int           idx;
        int           guard;

        // Reset state
        #2;
        check("rst_valid", W'(ex_valid), '0);
        check("rst_data", ex_data, '0);
        check("rst_allow", W'(allow), W'(1));
        @(negedge clk);
        reset = 1'b1;

        // Stream 0x1..0x8, each visible one edge after its accept
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, W'(k), 1'b1, 1'b0, acc);
            #1;
            check("stream_valid", W'(ex_valid), W'(1));
            check("stream_data", ex_data, W'(k));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Stall with 0xA, 0xB, 0xC
        pk[0] = 'hA; pk[1] = 'hB; pk[2] = 'hC;
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, pk[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        #1;
        check("stall_head", ex_data, 'hA);
        check("stall_allow", W'(allow), '0);
        ex_allow_in = 1'b1;
        #1;
        check("stall_allow_comb", W'(allow), SKID ? W'(0) : W'(1));
        ex_allow_in = 1'b0;
        guard = 0;
        while ((idx < 3 || exp_q.size() != 0) && guard < 20) begin
            d = (idx < 3) ? pk[idx % 3] : '0;
            cycle(idx < 3, d, 1'b1, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        check("release_done", W'(guard < 20), W'(1));

        // Flush while full (skid) / occupied (single) with incoming 0xD
        cycle(1'b1, 'h1, 1'b0, 1'b0, acc);
        cycle(1'b1, 'h2, 1'b0, 1'b0, acc);
        cycle(1'b1, 'hD, 1'b0, 1'b1, acc);
        #1;
        check("flush_valid", W'(ex_valid), '0);
        cycle(1'b1, 'hD, 1'b1, 1'b0, acc);
        #1;
        check("post_flush_valid", W'(ex_valid), W'(1));
        check("post_flush_data", ex_data, 'hD);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-stream
        cycle(1'b1, 'h11, 1'b0, 1'b0, acc);
        cycle(1'b1, 'h12, 1'b0, 1'b0, acc);
        #3;
        reset = 1'b0;
        #1;
        check("rst2_valid", W'(ex_valid), '0);
        check("rst2_data", ex_data, '0);
        exp_q.delete();
        ds_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 'h5, 1'b1, 1'b0, acc);
        #1;
        check("rst2_first_valid", W'(ex_valid), W'(1));
        check("rst2_first_data", ex_data, 'h5);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);

        // Random traffic with unique sequence numbers
        seq = 'h1000;
        for (int k = 0; k < 10000; k++) begin
            cycle($urandom_range(0, 3) != 0, seq, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, acc);
            if (acc) seq = seq + 1'b1;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            guard++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        #1;
        check("final_empty", W'(ex_valid), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
